axi_lite_sram_responder: RTL and testbench
==========================================

// Module: axi_lite_sram_responder
// PURPOSE
//  AXI4-Lite responder (slave) backed by an internal word-addressed SRAM array.
//  It is the far end of the LSU/IFU master port: it accepts AR, AW and W independently and returns R and B.
//  Used as the on-chip SRAM target behind the xbar, and as a bench memory model for master-side verification.
// PARAMETERS
//  ADDR_BASE    32'h0f00_0000  byte address of word 0
//  DEPTH_WORDS  2048           array depth in 32-bit words (power of 2)
//  LATENCY      1              cycles from accept to rvalid/bvalid (>=1)
//  LFSR_SEED    16'hACE1       seed for the random-delay LFSR (RAND_DELAY only)
// PORTS
//  clk     in   1   clock
//  rst     in   1   reset, synchronous, active-high
//  araddr  in   32  read address
//  arvalid in   1   read address valid
//  arready out  1   read address accepted
//  arsize  in   3   0=byte,1=half,2=word; recorded only, full word always returned
//  rdata   out  32  aligned word at araddr[31:2]
//  rresp   out  2   00 OKAY, 10 SLVERR
//  rvalid  out  1   read data valid
//  rready  in   1   master accepts read data
//  awaddr  in   32  write address
//  awvalid in   1   write address valid
//  awready out  1   write address accepted
//  wdata   in   32  lane-aligned write data
//  wstrb   in   4   byte enables
//  wvalid  in   1   write data valid
//  wready  out  1   write data accepted
//  bresp   out  2   00 OKAY, 10 SLVERR
//  bvalid  out  1   write response valid
//  bready  in   1   master accepts write response
// BEHAVIOUR
//  States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP. Reset -> IDLE; every output 0 (rdata 0, resp 00).
//  In range: ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS; index = (addr-ADDR_BASE)>>2; low 2 bits ignored.
//  Ready signals are combinational from state and latch flags only, never from valid.
//  arready = IDLE && !aw_got && !w_got. AR handshake -> latch addr and in-range flag; cnt=LATENCY-1; go to RD_WAIT.
//  awready = IDLE && !aw_got && !(arvalid&&arready); wready = IDLE && !w_got && !(arvalid&&arready).
//  Same cycle AR and AW/W in IDLE with nothing latched: read wins; AW/W are accepted after the read completes.
//  AW and W are accepted in either order or in the same cycle. Once both are latched -> WR_WAIT, cnt=LATENCY-1.
//  A partially latched write blocks reads until its B handshake completes.
//  RD_WAIT: decrement cnt; at cnt==0, register rdata=mem[idx] (0 if out of range), rresp, rvalid=1 -> RD_RESP.
//  RD_RESP: hold rdata/rresp/rvalid stable until rready; on handshake rvalid=0, -> IDLE.
//  WR_WAIT: at cnt==0, commit to memory: byte lane i written iff wstrb[i] && in range; bvalid=1 -> WR_RESP.
//  WR_RESP: hold bvalid/bresp until bready; on handshake clear aw_got/w_got, -> IDLE.
//  Out-of-range: no array write; resp=2'b10, rdata=0. wstrb=0 gives OKAY with no write.
//  LATENCY=1: response valid exactly 1 cycle after the accepting edge. Min throughput 1 txn per LATENCY+2 cycles.
//  Reset mid-transaction: latches and counter cleared, no response issued, array unchanged unless already committed.
//  Array contents are not reset.
// CONFIGURATION
//  AXI_SRAM_RAND_DELAY_EN defined: each accept loads cnt from a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed LFSR_SEED).
//   cnt = lfsr[2:0], giving 1..8 cycles of latency. The LFSR advances every clock and reloads LFSR_SEED on rst.
//   arready/awready/wready are additionally gated low when lfsr[3]==1, for backpressure testing.
//  Not defined: fixed LATENCY, no ready gating, no LFSR logic.
// TESTING
//  Write awaddr=0x0f00_0004, wdata=0xDEADBEEF, wstrb=1111 -> bvalid after LATENCY, bresp=00; read at 0x0f00_0004 -> rdata=0xDEADBEEF, rresp=00.
//  Byte write wstrb=0010, wdata=0x0000_5A00 over 0xDEADBEEF -> read returns 0xDEAD5AEF.
//  W presented 3 cycles before AW -> wready on first cycle, awready later, single B response, data committed once.
//  Same-cycle arvalid+awvalid+wvalid in IDLE -> arready=1, awready=wready=0; R completes first, then write proceeds.
//  Read at 0x1000_0000 -> rresp=10, rdata=0; write there -> bresp=10, array unchanged.
//  rready held low 5 cycles -> rvalid and rdata stable; rst asserted in WR_WAIT -> no bvalid, target word unchanged.

Source files
------------

// File: rtl/axi_lite_sram_responder.sv
// AXI4-Lite responder backed by an internal word-addressed SRAM; one transaction in flight.
// Optional macro AXI_SRAM_RAND_DELAY_EN: LFSR-driven response latency and ready backpressure.
module axi_lite_sram_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0f00_0000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          LATENCY     = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [2:0]  arsize,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, ADDR_BASE}) && ({1'b0, addr} < ADDR_END);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - ADDR_BASE) >> 2);
  endfunction

  state_t             state_r, state_s;
  logic               aw_got_r, w_got_r, rd_ok_r, wr_ok_r;
  logic [IDX_W-1:0]   rd_idx_r, wr_idx_r;
  logic [31:0]        wdata_r;
  logic [3:0]         wstrb_r;
  logic [2:0]         arsize_r;
  logic [15:0]        cnt_r, lat_load_s;
  logic               gate_s, unused_s;
  logic               ar_hs_s, aw_hs_s, w_hs_s, cnt_zero_s, wr_commit_s;
  logic [31:0]        mem_r [DEPTH_WORDS];

`ifdef AXI_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr_r;

  // Free-running LFSR x^16+x^14+x^13+x^11+1, reseeded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  assign lat_load_s = {13'd0, lfsr_r[2:0]};
  assign gate_s     = ~lfsr_r[3];
  assign unused_s   = ^{arsize_r, 16'(LATENCY)};
`else
  assign lat_load_s = 16'(LATENCY - 1);
  assign gate_s     = 1'b1;
  assign unused_s   = ^{arsize_r, LFSR_SEED};
`endif

  // Readies depend only on state and latch flags (plus the AR-wins arbitration)
  assign arready     = (state_r == IDLE) && !aw_got_r && !w_got_r && gate_s;
  assign ar_hs_s     = arvalid && arready;
  assign awready     = (state_r == IDLE) && !aw_got_r && !ar_hs_s && gate_s;
  assign wready      = (state_r == IDLE) && !w_got_r && !ar_hs_s && gate_s;
  assign aw_hs_s     = awvalid && awready;
  assign w_hs_s      = wvalid && wready;
  assign cnt_zero_s  = (cnt_r == 16'd0);
  assign wr_commit_s = (state_r == WR_WAIT) && cnt_zero_s;

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ar_hs_s) begin
          state_s = RD_WAIT;
        end else if ((aw_got_r || aw_hs_s) && (w_got_r || w_hs_s)) begin
          state_s = WR_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: state_s = cnt_zero_s ? RD_RESP : RD_WAIT;
      RD_RESP: state_s = rready ? IDLE : RD_RESP;
      WR_WAIT: state_s = cnt_zero_s ? WR_RESP : WR_WAIT;
      WR_RESP: state_s = bready ? IDLE : WR_RESP;
      default: state_s = IDLE;
    endcase
  end

  // State, request latches, latency counter and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      aw_got_r <= 1'b0;
      w_got_r  <= 1'b0;
      rd_ok_r  <= 1'b0;
      wr_ok_r  <= 1'b0;
      rd_idx_r <= '0;
      wr_idx_r <= '0;
      wdata_r  <= 32'd0;
      wstrb_r  <= 4'd0;
      arsize_r <= 3'd0;
      cnt_r    <= 16'd0;
      rdata    <= 32'd0;
      rresp    <= 2'b00;
      rvalid   <= 1'b0;
      bresp    <= 2'b00;
      bvalid   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (ar_hs_s) begin
        rd_ok_r  <= in_range(araddr);
        rd_idx_r <= word_idx(araddr);
        arsize_r <= arsize;
      end
      if (aw_hs_s) begin
        aw_got_r <= 1'b1;
        wr_ok_r  <= in_range(awaddr);
        wr_idx_r <= word_idx(awaddr);
      end
      if (w_hs_s) begin
        w_got_r <= 1'b1;
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
      if ((state_r == IDLE) && (state_s != IDLE)) begin
        cnt_r <= lat_load_s;
      end else if (((state_r == RD_WAIT) || (state_r == WR_WAIT)) && !cnt_zero_s) begin
        cnt_r <= cnt_r - 16'd1;
      end
      if ((state_r == RD_WAIT) && cnt_zero_s) begin
        rdata  <= rd_ok_r ? mem_r[rd_idx_r] : 32'd0;
        rresp  <= rd_ok_r ? 2'b00 : 2'b10;
        rvalid <= 1'b1;
      end else if ((state_r == RD_RESP) && rready) begin
        rvalid <= 1'b0;
      end
      if (wr_commit_s) begin
        bresp  <= wr_ok_r ? 2'b00 : 2'b10;
        bvalid <= 1'b1;
      end else if ((state_r == WR_RESP) && bready) begin
        bvalid   <= 1'b0;
        aw_got_r <= 1'b0;
        w_got_r  <= 1'b0;
      end
    end
  end

  // SRAM array: contents survive reset, byte lanes written only on an in-range commit
  always_ff @(posedge clk) begin
    if (!rst && wr_commit_s && wr_ok_r) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_r[i]) begin
          mem_r[wr_idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// Randomized scoreboard bench for axi_lite_sram_responder (default build, LATENCY=1).
module tb_axi_lite_sram_responder;

  localparam logic [31:0] BASE  = 32'h0f00_0000;
  localparam int          DEPTH = 2048;
  localparam int          LAT   = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic [2:0]  arsize;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  axi_lite_sram_responder #(
    .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arsize(arsize),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          vectors = 0;
  int          errors  = 0;
  int          r_hs_cnt = 0;
  int          b_hs_cnt = 0;
  rexp_t       exp_r_q[$];
  logic [1:0]  exp_b_q[$];
  logic [31:0] model [int unsigned];

  function automatic bit in_rng(input logic [31:0] a);
    longint la;
    la = longint'(a);
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 64'(4 * DEPTH));
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic rexp_t read_exp(input logic [31:0] a);
    rexp_t e;
    if (in_rng(a)) begin
      e.data = model.exists(idx_of(a)) ? model[idx_of(a)] : 32'd0;
      e.resp = 2'b00;
    end else begin
      e.data = 32'd0;
      e.resp = 2'b10;
    end
    return e;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (in_rng(a)) begin
      w = model.exists(idx_of(a)) ? model[idx_of(a)] : 32'd0;
      for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model[idx_of(a)] = w;
      exp_b_q.push_back(2'b00);
    end else begin
      exp_b_q.push_back(2'b10);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every cycle a response is presented, pop on handshake
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      vectors++;
      if (exp_r_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got rdata=%h rresp=%b, expected no response", rdata, rresp);
      end else if (rdata !== exp_r_q[0].data || rresp !== exp_r_q[0].resp) begin
        errors++;
        $display("FAIL r_data: got %h/%b, expected %h/%b", rdata, rresp, exp_r_q[0].data, exp_r_q[0].resp);
      end
      if (rready) begin
        if (exp_r_q.size() != 0) void'(exp_r_q.pop_front());
        r_hs_cnt++;
      end
    end
    if (!rst && bvalid) begin
      vectors++;
      if (exp_b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got bresp=%b, expected no response", bresp);
      end else if (bresp !== exp_b_q[0]) begin
        errors++;
        $display("FAIL b_resp: got %b, expected %b", bresp, exp_b_q[0]);
      end
      if (bready) begin
        if (exp_b_q.size() != 0) void'(exp_b_q.pop_front());
        b_hs_cnt++;
      end
    end
  end

  task automatic wait_valid(input bit is_r);
    int lat = 0;
    @(negedge clk);
    while (!(is_r ? rvalid : bvalid) && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check(is_r ? "r_latency" : "b_latency", 32'(lat), 32'(LAT));
  endtask

  task automatic hold_and_accept(input bit is_r, input int hold);
    int start = is_r ? r_hs_cnt : b_hs_cnt;
    int n = 0;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    if (is_r) rready = 1'b1; else bready = 1'b1;
    while ((is_r ? r_hs_cnt : b_hs_cnt) == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      vectors++; errors++;
      $display("FAIL %s_handshake: got no handshake, expected one within 50 cycles", is_r ? "r" : "b");
    end
    rready = 1'b0;
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    bit hs = 1'b0;
    int n = 0;
    exp_r_q.push_back(read_exp(a));
    araddr = a; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = arready;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      vectors++; errors++;
      $display("FAIL ar_accept: got no arready, expected one within 50 cycles");
    end
    wait_valid(1'b1);
    hold_and_accept(1'b1, hold);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input bit with_read,
                          input bit chk, input int hold);
    bit aw_done = 1'b0, w_done = 1'b0, ar_done = 1'b0;
    bit aw_h, w_h, ar_h;
    int cyc = 0;
    if (with_read) exp_r_q.push_back(read_exp(a));
    model_write(a, d, s);
    awaddr = a; wdata = d; wstrb = s; araddr = a; arsize = 3'd2;
    while (!(aw_done && w_done) && cyc < 60) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      arvalid = with_read && !ar_done;
      rready  = with_read;
      @(negedge clk);
      if (chk && cyc == 0) begin
        if (with_read) begin
          check("same_arready", 32'(arready), 32'd1);
          check("same_awready", 32'(awready), 32'd0);
          check("same_wready", 32'(wready), 32'd0);
        end else begin
          check("wfirst_wready", 32'(wready), 32'd1);
        end
      end
      aw_h = awvalid && awready;
      w_h  = wvalid && wready;
      ar_h = arvalid && arready;
      @(posedge clk); #1;
      if (aw_h) aw_done = 1'b1;
      if (w_h) w_done = 1'b1;
      if (ar_h) ar_done = 1'b1;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      vectors++; errors++;
      $display("FAIL aw_w_accept: got aw=%0d w=%0d, expected both accepted", aw_done, w_done);
    end
    if (with_read) check("read_before_write", 32'(exp_r_q.size()), 32'd0);
    rready = 1'b0;
    wait_valid(1'b0);
    hold_and_accept(1'b0, hold);
  endtask

  task automatic write_then_reset(input logic [31:0] a, input logic [31:0] d);
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("rst_aw_w_accept", 32'(awready && wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rst_no_bvalid", 32'(bvalid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          r;
    rst = 1'b1; arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    araddr = 32'd0; awaddr = 32'd0; wdata = 32'd0; wstrb = 4'd0; arsize = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 1'b0, 1'b0, 0);

    do_write(32'h0f00_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 1'b0, 1'b0, 0);
    do_read(32'h0f00_0004, 0);
    do_write(32'h0f00_0004, 32'h0000_5A00, 4'b0010, 0, 0, 1'b0, 1'b0, 1);
    do_read(32'h0f00_0004, 0);
    check("model_dead5aef", model[1], 32'hDEAD_5AEF);
    do_write(32'h0f00_0008, 32'h1234_5678, 4'hF, 3, 0, 1'b0, 1'b1, 0);
    do_read(32'h0f00_0008, 0);
    do_write(32'h0f00_000c, 32'hCAFE_F00D, 4'hF, 0, 0, 1'b1, 1'b1, 0);
    do_read(32'h0f00_000c, 0);
    do_read(32'h1000_0000, 0);
    do_write(32'h1000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b0, 1'b0, 0);
    do_read(BASE, 0);
    do_write(BASE + 32'(4 * DEPTH - 4), 32'hA5A5_5A5A, 4'hF, 0, 0, 1'b0, 1'b0, 0);
    do_read(BASE + 32'(4 * DEPTH - 4), 0);
    do_read(BASE + 32'(4 * DEPTH), 0);
    do_write(BASE - 32'd4, 32'h0BAD_0BAD, 4'hF, 0, 0, 1'b0, 1'b0, 0);
    do_read(BASE - 32'd4, 0);
    do_write(32'h0f00_0010, 32'h0000_0000, 4'b0000, 0, 0, 1'b0, 1'b0, 2);
    do_read(32'h0f00_0010, 5);
    write_then_reset(32'h0f00_0014, 32'h7777_7777);
    do_read(32'h0f00_0014, 0);

    for (int t = 0; t < 80; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (r < 90) a = 32'h1000_0000 + 32'($urandom_range(0, 4095));
      else a = BASE - 32'd4 - 32'(4 * $urandom_range(0, 63));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) do_read(a, int'($urandom_range(0, 3)));
      else do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'b0, 1'b0, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
